// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier and its 16-bit adder.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int ACC_W = 16;

endpackage

// File: rtl/fulladder.sv
// 16-bit ripple-carry adder: one full-adder cell per bit, carry chained LSB to MSB.
module fulladder
    import seq_mult_pkg::*;
(
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    input  logic             cin,
    output logic [ACC_W-1:0] sum,
    output logic             cout
);

    logic w_carry;

    always_comb begin
        w_carry = cin;
        sum     = '0;
        for (int i = 0; i < ACC_W; i++) begin
            sum[i]  = a[i] ^ b[i] ^ w_carry;
            w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
        end
        cout = w_carry;
    end

endmodule

// File: rtl/seq_mult8.sv
// Sequential shift-and-add unsigned multiplier, one add step per clock, valid/ready in and out.
// Define EARLY_TERM_EN to leave CALC as soon as the remaining multiplier bits are all zero.
module seq_mult8
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [CNT_W-1:0]   r_step_cnt;
    logic [ACC_W-1:0]   w_sum;
    logic               w_cout;
    logic               w_last_step;

    fulladder u_adder (
        .a    (r_acc),
        .b    (r_mcand),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

`ifdef EARLY_TERM_EN
    assign w_last_step = (r_step_cnt == CNT_W'(WIDTH - 1)) || ((r_mplr >> 1) == '0);
`else
    assign w_last_step = (r_step_cnt == CNT_W'(WIDTH - 1));
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)    w_state_nxt = CALC;
            CALC:    if (w_last_step) w_state_nxt = DONE;
            DONE:    if (out_ready)   w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplr     <= '0;
            r_step_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: if (in_valid) begin
                    r_mcand    <= {{(ACC_W - WIDTH){1'b0}}, a};
                    r_mplr     <= b;
                    r_acc      <= '0;
                    r_step_cnt <= '0;
                end
                CALC: begin
                    if (r_mplr[0]) r_acc <= w_sum;
                    r_mcand    <= r_mcand << 1;
                    r_mplr     <= r_mplr >> 1;
                    r_step_cnt <= r_step_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Operands are bounded so the 16-bit accumulator can never carry out.
    always_ff @(posedge clk) begin
        if (rst_n && (r_state == CALC) && r_mplr[0]) begin
            assert (!w_cout);
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == CALC);
    assign product   = r_acc[2*WIDTH-1:0];

endmodule

// File: tb/tb_seq_mult8.sv
// Self-checking bench for seq_mult8: table vectors, hand-written corner sequences, random back-to-back run.
module tb_seq_mult8;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] product;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [2*W-1:0] sb_q[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;
    vec_t vecs[9];

    always #5 clk = ~clk;

    seq_mult8 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [7:0] bv);
`ifdef EARLY_TERM_EN
        int m;
        m = 0;
        for (int i = 0; i < 8; i++) if (bv[i]) m = i + 1;
        return (m < 1) ? 1 : m;
`else
        return W;
`endif
    endfunction

    function automatic logic [15:0] sb_pop();
        if (sb_q.size() == 0) return 16'hxxxx;
        return sb_q.pop_front();
    endfunction

    // One full transaction: accept, wait for DONE, optionally stall the consumer, then drain.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [15:0] tp,
                          input int hold, input string name);
        int lat;
        logic [15:0] exp_p;
        @(negedge clk);
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        a = ta;
        b = tb_;
        in_valid = 1'b1;
        sb_q.push_back(tp);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat(tb_)));
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                a = 8'd9;
                b = 8'd9;
                in_valid = 1'b1;
            end
            check({name, "_hold_prod"}, 32'(product), 32'(tp));
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        exp_p = sb_pop();
        check({name, "_product"}, 32'(product), 32'(exp_p));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_drained_valid"}, 32'(out_valid), 32'd0);
        check({name, "_drained_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int cyc;
        int last_acc;
        int n_acc;
        int n_done;

        vecs[0] = '{8'd13,  8'd11,  16'd143};
        vecs[1] = '{8'd255, 8'd255, 16'd65025};
        vecs[2] = '{8'd200, 8'd0,   16'd0};
        vecs[3] = '{8'd0,   8'd200, 16'd0};
        vecs[4] = '{8'd1,   8'd1,   16'd1};
        vecs[5] = '{8'd128, 8'd2,   16'd256};
        vecs[6] = '{8'd255, 8'd1,   16'd255};
        vecs[7] = '{8'd1,   8'd255, 16'd255};
        vecs[8] = '{8'd170, 8'd85,  16'd14450};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p, 0, $sformatf("vec%0d", i));

        run_op(8'd3, 8'd7, 16'd21, 5, "stall");

        // Abort an operation mid-calculation with reset.
        @(negedge clk);
        a = 8'd100;
        b = 8'd100;
        in_valid = 1'b1;
        sb_q.push_back(16'd10000);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        void'(sb_pop());
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        run_op(8'd2, 8'd3, 16'd6, 0, "after_abort");

        // Back-to-back random operations with in_valid and out_ready held high.
        cyc = 0;
        last_acc = 0;
        n_acc = 0;
        n_done = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (n_done < 1000 && cyc < 30000) begin
            if (out_valid) begin
                check("rand_product", 32'(product), 32'(sb_pop()));
                n_done++;
            end
            if (in_ready && n_acc < 1000) begin
`ifndef EARLY_TERM_EN
                if (n_acc > 0) check("b2b_spacing", 32'(cyc - last_acc), 32'(W + 2));
`endif
                last_acc = cyc;
                a = 8'($urandom);
                b = 8'($urandom);
                in_valid = 1'b1;
                sb_q.push_back(16'(a) * 16'(b));
                n_acc++;
            end else if (n_acc >= 1000) begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("rand_ops_done", 32'(n_done), 32'd1000);
        check("rand_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
